// File: rtl/lcd_msg_scheduler.sv
// lcd_msg_scheduler
//   Picks which of five fixed two-line messages the LCD shows and asks the LCD
//   driver to redraw it. The banner (0) is shown after reset. Rising edges on
//   iREQ queue messages 1..4, which are served round-robin. Each served message
//   stays on the display for at least HOLD_CYCLES clocks.
//
// Ports
//   iCLK     in   system clock, rising edge
//   iRST_N   in   asynchronous active-low reset
//   iREQ     in   [3:0] message request levels (bit n -> message n+1)
//   iADDR    in   [4:0] character position (0-15 line 1, 16-31 line 2)
//   iDONE    in   driver pulse: full redraw complete
//   oCHAR    out  [8:0] {RS=1, ASCII} for iADDR, one cycle latency
//   oMSG_ID  out  [2:0] message currently displayed
//   oUPDATE  out  redraw request, held until iDONE
//   oBUSY    out  high whenever not idle
module lcd_msg_scheduler #(
    parameter int unsigned HOLD_CYCLES = 50000000
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic [3:0] iREQ,
    input  logic [4:0] iADDR,
    input  logic       iDONE,
    output logic [8:0] oCHAR,
    output logic [2:0] oMSG_ID,
    output logic       oUPDATE,
    output logic       oBUSY
);

    typedef enum logic [1:0] {BOOT, IDLE, REFRESH, HOLD} state_t;

    localparam logic [25:0] HOLD_LAST = 26'(HOLD_CYCLES - 1);

    state_t      state;
    logic [3:0]  req_q;
    logic [3:0]  pending;
    logic [3:0]  edges;
    logic [3:0]  grant_mask;
    logic [1:0]  last_grant;
    logic [1:0]  grant_idx;
    logic [1:0]  probe;
    logic        grant_found;
    logic [25:0] hold_cnt;

    // Character table: each line is exactly 16 characters, space padded.
    function automatic logic [7:0] char_lookup(input logic [2:0] id,
                                               input logic [4:0] addr);
        logic [127:0] line;
        logic [127:0] shifted;
        case ({id, addr[4]})
            4'b0000: line = "HOLA MUNDO LINE1";
            4'b0001: line = "PRUEBA LINEA 2  ";
            4'b0010: line = " BIENVENIDO     ";
            4'b0011: line = "DISPONIBLE      ";
            4'b0100: line = " CONTANDO       ";
            4'b0101: line = " TIEMPO         ";
            4'b0110: line = " POR FAVOR PAGAR";
            4'b1000: line = " GRACIAS        ";
            4'b1001: line = " VUELVA PRONTO  ";
            default: line = {16{8'h20}};
        endcase
        shifted = line << {addr[3:0], 3'b000};
        return shifted[127:120];
    endfunction

    assign edges = iREQ & ~req_q;

    // Round-robin search starting one past the last grant.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_grant;
        probe       = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            probe = last_grant + 2'(i + 1);
            if (!grant_found && pending[probe]) begin
                grant_found = 1'b1;
                grant_idx   = probe;
            end
        end
    end

    always_comb begin
        grant_mask = '0;
        if (state == IDLE && grant_found)
            grant_mask[grant_idx] = 1'b1;
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= BOOT;
            req_q      <= '0;
            pending    <= '0;
            last_grant <= 2'd3;
            hold_cnt   <= '0;
            oMSG_ID    <= '0;
            oUPDATE    <= 1'b0;
            oBUSY      <= 1'b1;
            oCHAR      <= 9'h120;
        end else begin
            req_q   <= iREQ;
            // A new edge in the same cycle as its grant keeps the bit set.
            pending <= (pending & ~grant_mask) | edges;
            oCHAR   <= {1'b1, char_lookup(oMSG_ID, iADDR)};
            case (state)
                BOOT: begin
                    state   <= REFRESH;
                    oMSG_ID <= '0;
                    oUPDATE <= 1'b1;
                    oBUSY   <= 1'b1;
                end
                IDLE: begin
                    if (grant_found) begin
                        state      <= REFRESH;
                        oMSG_ID    <= {1'b0, grant_idx} + 3'd1;
                        last_grant <= grant_idx;
                        oUPDATE    <= 1'b1;
                        oBUSY      <= 1'b1;
                    end
                end
                REFRESH: begin
                    if (iDONE) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                        oUPDATE  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state <= IDLE;
                        oBUSY <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 26'd1;
                    end
                end
                default: begin
                    state   <= BOOT;
                    oUPDATE <= 1'b0;
                    oBUSY   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_msg_scheduler.sv
// tb_lcd_msg_scheduler
//   Directed bench for lcd_msg_scheduler with HOLD_CYCLES = 8. A reference
//   model tracks the expected display behaviour alongside the design.
module tb_lcd_msg_scheduler;

    localparam int H = 8;

    logic       iCLK;
    logic       iRST_N;
    logic [3:0] iREQ;
    logic [4:0] iADDR;
    logic       iDONE;
    logic [8:0] oCHAR;
    logic [2:0] oMSG_ID;
    logic       oUPDATE;
    logic       oBUSY;

    int n_tests = 0;
    int n_fail  = 0;

    lcd_msg_scheduler #(.HOLD_CYCLES(H)) dut (
        .iCLK    (iCLK),
        .iRST_N  (iRST_N),
        .iREQ    (iREQ),
        .iADDR   (iADDR),
        .iDONE   (iDONE),
        .oCHAR   (oCHAR),
        .oMSG_ID (oMSG_ID),
        .oUPDATE (oUPDATE),
        .oBUSY   (oBUSY)
    );

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    string txt [5][2] = '{
        '{"HOLA MUNDO LINE1", "PRUEBA LINEA 2"},
        '{" BIENVENIDO",      "DISPONIBLE"},
        '{" CONTANDO",        " TIEMPO"},
        '{" POR FAVOR PAGAR", ""},
        '{" GRACIAS",         " VUELVA PRONTO"}
    };

    bit         m_boot;
    bit         m_draw;
    int         m_hold;
    int         m_msg;
    int         m_last;
    bit   [3:0] m_pend;
    bit   [3:0] m_prev;
    logic [8:0] m_char;

    function automatic logic [7:0] msg_byte(input int id, input logic [4:0] a);
        string s;
        int    pos;
        if (id < 0 || id > 4) return 8'h20;
        s   = txt[id][int'(a[4])];
        pos = int'(a[3:0]);
        if (pos < s.len()) return 8'(s.getc(pos));
        return 8'h20;
    endfunction

    function automatic int rr_pick(input bit [3:0] pend, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (pend[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    function automatic bit m_idle();
        return !m_boot && !m_draw && (m_hold == 0);
    endfunction

    function automatic bit [3:0] served();
        int p;
        p = rr_pick(m_pend, m_last);
        if (m_idle() && p >= 0) return 4'(1 << p);
        return 4'b0000;
    endfunction

    always @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            m_boot <= 1'b1;
            m_draw <= 1'b0;
            m_hold <= 0;
            m_msg  <= 0;
            m_last <= 3;
            m_pend <= '0;
            m_prev <= '0;
            m_char <= 9'h120;
        end else begin
            m_prev <= iREQ;
            m_char <= {1'b1, msg_byte(m_msg, iADDR)};
            m_pend <= (m_pend & ~served()) | (iREQ & ~m_prev);
            if (m_boot) begin
                m_boot <= 1'b0;
                m_draw <= 1'b1;
                m_msg  <= 0;
            end else if (m_draw) begin
                if (iDONE) begin
                    m_draw <= 1'b0;
                    m_hold <= H;
                end
            end else if (m_hold > 0) begin
                m_hold <= m_hold - 1;
            end else if (rr_pick(m_pend, m_last) >= 0) begin
                m_msg  <= rr_pick(m_pend, m_last) + 1;
                m_last <= rr_pick(m_pend, m_last);
                m_draw <= 1'b1;
            end
        end
    end

    always @(negedge iCLK) begin
        check("model_char",   32'(oCHAR),   32'(m_char));
        check("model_msg",    32'(oMSG_ID), m_msg);
        check("model_update", 32'(oUPDATE), 32'(m_draw));
        check("model_busy",   32'(oBUSY),   32'(m_boot || m_draw || (m_hold > 0)));
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge iCLK);
        #2;
    endtask

    task automatic done_pulse();
        iDONE = 1'b1;
        step();
        iDONE = 1'b0;
    endtask

    initial begin
        iRST_N = 1'b0;
        iREQ   = '0;
        iADDR  = '0;
        iDONE  = 1'b0;
        repeat (3) @(posedge iCLK);
        #2;
        check("rst_busy",   32'(oBUSY),   32'd1);
        check("rst_update", 32'(oUPDATE), 32'd0);
        check("rst_char",   32'(oCHAR),   32'h120);
        check("rst_msg",    32'(oMSG_ID), 32'd0);

        // Reset release: one BOOT cycle, then banner redraw.
        iRST_N = 1'b1;
        #3;
        check("boot_update", 32'(oUPDATE), 32'd0);
        check("boot_busy",   32'(oBUSY),   32'd1);
        step();
        check("banner_update", 32'(oUPDATE), 32'd1);
        check("banner_msg",    32'(oMSG_ID), 32'd0);
        repeat (4) step();
        done_pulse();
        check("done_drop", 32'(oUPDATE), 32'd0);
        repeat (7) step();
        check("hold_busy", 32'(oBUSY), 32'd1);
        step();
        check("hold_end", 32'(oBUSY), 32'd0);
        iADDR = 5'd0;
        step();
        check("char_H", 32'(oCHAR), 32'h148);

        // Single request from idle.
        iREQ = 4'b0001;
        step();
        check("req1_wait", 32'(oUPDATE), 32'd0);
        step();
        check("req1_msg", 32'(oMSG_ID), 32'd1);
        check("req1_upd", 32'(oUPDATE), 32'd1);
        iADDR = 5'd1;
        step();
        check("char_B", 32'(oCHAR), 32'h142);
        done_pulse();
        repeat (H) step();
        check("req1_idle", 32'(oBUSY), 32'd0);
        iREQ = 4'b0000;
        step();

        // Two simultaneous edges, last_grant = 0.
        iREQ = 4'b1010;
        step();
        step();
        check("rr_first", 32'(oMSG_ID), 32'd2);
        done_pulse();
        repeat (H) step();
        check("rr_gap_busy", 32'(oBUSY),   32'd0);
        check("rr_gap_msg",  32'(oMSG_ID), 32'd2);
        step();
        check("rr_second", 32'(oMSG_ID), 32'd4);
        check("rr_upd",    32'(oUPDATE), 32'd1);
        done_pulse();
        repeat (H) step();
        iREQ = 4'b0000;
        step();

        // Held level served once; a fresh edge is served again.
        iREQ = 4'b0100;
        repeat (2) step();
        check("held_msg", 32'(oMSG_ID), 32'd3);
        done_pulse();
        repeat (H) step();
        repeat (12) step();
        check("held_once_busy", 32'(oBUSY),   32'd0);
        check("held_once_msg",  32'(oMSG_ID), 32'd3);
        iREQ = 4'b0101;
        repeat (2) step();
        check("between_msg", 32'(oMSG_ID), 32'd1);
        done_pulse();
        repeat (H) step();
        iREQ = 4'b0001;
        step();
        iREQ = 4'b0101;
        repeat (2) step();
        check("retoggle_msg", 32'(oMSG_ID), 32'd3);
        check("retoggle_upd", 32'(oUPDATE), 32'd1);
        done_pulse();
        repeat (H) step();
        iREQ = 4'b0000;
        step();

        // Edge during HOLD is deferred until HOLD ends.
        iREQ = 4'b0001;
        repeat (2) step();
        done_pulse();
        repeat (3) step();
        iREQ = 4'b1001;
        repeat (5) step();
        check("defer_busy", 32'(oBUSY),   32'd0);
        check("defer_upd",  32'(oUPDATE), 32'd0);
        step();
        check("defer_msg", 32'(oMSG_ID), 32'd4);
        check("defer_upd2", 32'(oUPDATE), 32'd1);
        iADDR = 5'd16;
        step();
        check("char_sp16", 32'(oCHAR), 32'h120);
        iADDR = 5'd17;
        step();
        check("char_V", 32'(oCHAR), 32'h156);
        done_pulse();
        repeat (H) step();
        iREQ = 4'b0000;
        step();

        // Reset during REFRESH with two requests still pending.
        iREQ = 4'b0111;
        repeat (2) step();
        step();
        check("pre_rst_upd", 32'(oUPDATE), 32'd1);
        check("pre_rst_msg", 32'(oMSG_ID), 32'd1);
        #1 iRST_N = 1'b0;
        #1;
        check("async_upd",  32'(oUPDATE), 32'd0);
        check("async_busy", 32'(oBUSY),   32'd1);
        check("async_msg",  32'(oMSG_ID), 32'd0);
        check("async_char", 32'(oCHAR),   32'h120);
        iREQ = 4'b0000;
        repeat (2) step();
        iRST_N = 1'b1;
        step();
        check("rerst_upd", 32'(oUPDATE), 32'd1);
        check("rerst_msg", 32'(oMSG_ID), 32'd0);
        done_pulse();
        repeat (H) step();
        repeat (6) step();
        check("no_stale_busy", 32'(oBUSY),   32'd0);
        check("no_stale_msg",  32'(oMSG_ID), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_msg_scheduler.md
LCD_MSG_SCHEDULER -- requirements
Module: lcd_msg_scheduler

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 50000000, giving the minimum display time of each message in iCLK cycles (1 s at 50 MHz); legal range 1..2^26-1.
REQ-002 iCLK  input  1  system clock (50 MHz); all state changes on its rising edge.
REQ-003 iRST_N  input  1  asynchronous, active-low reset.
REQ-004 iREQ  input  4  message request levels; bit0 = e_1 ... bit3 = e_4; asynchronous to nothing, treated as synchronous to iCLK.
REQ-005 iADDR  input  5  character position from the LCD driver; 0-15 = line 1, 16-31 = line 2.
REQ-006 iDONE  input  1  LCD driver pulse: redraw of all 32 positions complete.
REQ-007 oCHAR  output  9  character for iADDR, format {1'b1, ASCII[7:0]} (RS=data).
REQ-008 oMSG_ID  output  3  message currently displayed: 0 = banner, 1..4 = iREQ bit 0..3.
REQ-009 oUPDATE  output  1  redraw request to the LCD driver, level, held until iDONE.
REQ-010 oBUSY  output  1  high whenever state is not IDLE.

Function
REQ-011 Each iREQ bit SHALL be registered once; a 0->1 transition SHALL set the corresponding pending bit; a held-high level SHALL NOT re-set it.
REQ-012 States SHALL be BOOT, IDLE, REFRESH, HOLD; all outputs except oCHAR SHALL be Moore-decoded from state and registers.
REQ-013 BOOT SHALL last exactly one cycle and go to REFRESH with oMSG_ID = 0.
REQ-014 IDLE with any pending bit set SHALL grant one bit by round-robin, starting the search at (last_grant+1) mod 4, clear that pending bit, load oMSG_ID = granted index+1, update last_grant and go to REFRESH in the same cycle.
REQ-015 IDLE with no pending bit SHALL remain in IDLE; oMSG_ID SHALL be unchanged (no reversion to banner).
REQ-016 oUPDATE SHALL be 1 exactly while in REFRESH; iDONE sampled high in REFRESH SHALL go to HOLD with the hold counter cleared; iDONE outside REFRESH SHALL be ignored.
REQ-017 HOLD SHALL count 0..HOLD_CYCLES-1 and go to IDLE in the cycle after the count reaches HOLD_CYCLES-1 (HOLD lasts exactly HOLD_CYCLES cycles).
REQ-018 Edges arriving in BOOT, REFRESH or HOLD SHALL be latched as pending and served after HOLD; simultaneous edges SHALL all latch and be served in round-robin order.
REQ-019 A new edge on the bit of the message currently displayed SHALL be served normally (redraw of the same text).
REQ-020 A pending-bit set and its grant-clear in the same cycle SHALL leave the bit set (set wins).
REQ-021 oMSG_ID SHALL change only on the IDLE->REFRESH transition, so text never changes during a redraw.
REQ-022 oCHAR SHALL be registered, valid 1 cycle after iADDR, from a fixed 5x32 table indexed by oMSG_ID, space-padded to 16 per line:
  0: "HOLA MUNDO LINE1" / "PRUEBA LINEA 2"
  1: " BIENVENIDO" / "DISPONIBLE"
  2: " CONTANDO" / " TIEMPO"
  3: " POR FAVOR PAGAR" / (all spaces)
  4: " GRACIAS" / " VUELVA PRONTO"
REQ-023 oMSG_ID values 5-7 are unreachable; if decoded, oCHAR SHALL be 9'h120.

Reset
REQ-024 iRST_N low SHALL asynchronously force: state BOOT, oMSG_ID 0, oUPDATE 0, oBUSY 1, oCHAR 9'h120, pending 0, last_grant 3, hold counter 0, iREQ sample register 0.
REQ-025 Reset asserted mid-REFRESH or mid-HOLD SHALL abandon the operation and drop oUPDATE immediately; pending requests SHALL be lost.
REQ-026 After iRST_N rises, the block SHALL spend one cycle in BOOT and then assert oUPDATE for banner 0.

Verification (HOLD_CYCLES = 8)
REQ-027 Reset release, iDONE pulse 5 cycles after oUPDATE rises -> oMSG_ID = 0; oUPDATE falls the cycle after iDONE; oBUSY falls 8 cycles later; iADDR = 0 -> oCHAR = 9'h148 ('H').
REQ-028 iREQ = 4'b0001 rising in IDLE -> 2 cycles later oMSG_ID = 1 and oUPDATE = 1; iADDR = 1 -> oCHAR = 9'h142 ('B').
REQ-029 iREQ 0->4'b1010 in one cycle while IDLE, last_grant = 0 -> grants in order 2 then 4; each redraw is followed by 8 HOLD cycles.
REQ-030 iREQ bit2 held high through two full serve cycles -> served once only; toggle low-high -> served again, oMSG_ID = 3.
REQ-031 iREQ bit3 edge during HOLD -> no oUPDATE until HOLD ends; then oMSG_ID = 4; iADDR = 16 -> oCHAR = 9'h120, iADDR = 17 -> 9'h156 ('V').
REQ-032 iRST_N pulsed low during REFRESH with 2 pending bits -> oUPDATE drops asynchronously; after release, banner 0 is redrawn and no stale grant occurs.
